// File: rtl/tds_channel_readout_arbiter.sv
// tds_channel_readout_arbiter
// Round-robin readout scheduler for the TDS channel FIFOs. A channel becomes
// eligible once its fill level reaches counter_th or once it has been holding
// data for idle_th cycles. The granted channel is popped for a bounded burst
// and its words are forwarded on a registered valid/ready stream with
// first/last framing and a channel tag.
module tds_channel_readout_arbiter #(
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = 120,
    parameter int CNT_W     = 10,
    parameter int BURST_MAX = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [CNT_W-1:0]         counter_th,
    input  logic [15:0]              idle_th,
    input  logic [NUM_CH-1:0]        channel_linked,
    input  logic [NUM_CH-1:0]        ch_empty,
    input  logic [NUM_CH*CNT_W-1:0]  ch_count,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_read,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_first,
    output logic                     out_last,
    output logic [2:0]               out_ch,
    output logic                     busy,
    output logic                     underrun_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Channel index (base + off) wrapped into 0..NUM_CH-1; off < NUM_CH.
    function automatic logic [2:0] rr_index(input logic [2:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        sum = (sum >= NUM_CH) ? (sum - NUM_CH) : sum;
        return 3'(sum);
    endfunction

    // Registered state
    state_t           r_state;
    logic [2:0]       r_grant;
    logic [2:0]       r_rr_ptr;
    logic [CNT_W-1:0] r_words_left;
    logic             r_first_pend;
    logic             r_busy;
    logic             r_underrun;
    logic [15:0]      r_idle_tmr [NUM_CH];

    // Output stage registers
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_first;
    logic              r_out_last;

    // Combinational helpers
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_elig;
    logic              w_any_elig;
    logic [2:0]        w_pick;
    logic [2:0]        w_idx;
    logic [CNT_W-1:0]  w_grant_cnt;
    logic [CNT_W-1:0]  w_burst_len;
    logic              w_start;
    logic              w_pop;
    logic              w_accept;
    logic              w_starved;
    logic [NUM_CH-1:0] w_tmr_hold;
    logic [DATA_W-1:0] w_head;

    // Per-channel eligibility from fill level or idle timeout.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cnt[i]  = ch_count[i*CNT_W +: CNT_W];
            w_elig[i] = channel_linked[i] & ~ch_empty[i] &
                        ((w_cnt[i] >= counter_th) |
                         ((idle_th != 16'd0) & (r_idle_tmr[i] >= idle_th)));
        end
    end

    // Round-robin search: first eligible channel at or after rr_ptr.
    // Walking downward lets the lowest offset overwrite the others.
    always_comb begin
        w_any_elig = 1'b0;
        w_pick     = 3'd0;
        w_idx      = 3'd0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx      = rr_index(r_rr_ptr, k);
            w_pick     = w_elig[w_idx] ? w_idx : w_pick;
            w_any_elig = w_any_elig | w_elig[w_idx];
        end
    end

    // Burst length of a new grant. A channel that qualified on timeout may
    // report count 0 while holding a word, so at least one word is granted.
    always_comb begin
        w_grant_cnt = w_cnt[w_pick];
        w_burst_len = (w_grant_cnt > BURST_LIM) ? BURST_LIM : w_grant_cnt;
        if (w_burst_len == '0) begin
            w_burst_len = CNT_ONE;
        end else begin
            w_burst_len = w_burst_len;
        end
    end

    // Grant, pop, accept and stall qualifiers; pops are suppressed in reset.
    always_comb begin
        w_start   = (r_state == ST_IDLE) & enable & w_any_elig;
        w_accept  = r_out_valid & out_ready;
        w_starved = (r_state == ST_BURST) & ch_empty[r_grant] & (r_words_left != '0);
        w_pop     = reset_n & (r_state == ST_BURST) & (~r_out_valid | out_ready) &
                    ~ch_empty[r_grant] & (r_words_left != '0);
        w_head    = ch_data[int'(r_grant)*DATA_W +: DATA_W];
    end

    // One-hot FIFO pop strobe for the granted channel.
    always_comb begin
        ch_read = '0;
        if (w_pop) begin
            ch_read[r_grant] = 1'b1;
        end else begin
            ch_read = '0;
        end
    end

    // Idle timers are frozen at zero for empty channels and the granted channel.
    always_comb begin
        w_tmr_hold = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_tmr_hold[i] = ch_empty[i] |
                            (w_start & (w_pick == 3'(i))) |
                            ((r_state != ST_IDLE) & (r_grant == 3'(i)));
        end
    end

    // Next-state logic of the IDLE -> BURST -> DRAIN sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_BURST;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (w_pop && (r_words_left == CNT_ONE)) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_DRAIN: begin
                if (w_accept) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus grant bookkeeping and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 3'd0;
            r_rr_ptr     <= 3'd0;
            r_words_left <= '0;
            r_first_pend <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_start) begin
                r_grant      <= w_pick;
                r_words_left <= w_burst_len;
                r_first_pend <= 1'b1;
            end else if (w_pop) begin
                r_words_left <= r_words_left - CNT_ONE;
                r_first_pend <= 1'b0;
            end
            if ((r_state == ST_DRAIN) && w_accept) begin
                r_rr_ptr <= rr_index(r_grant, 1);
            end
        end
    end

    // Output word register: load on pop, retire on accept without a new pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_pop) begin
            r_out_data  <= w_head;
            r_out_valid <= 1'b1;
            r_out_first <= r_first_pend;
            r_out_last  <= (r_words_left == CNT_ONE);
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    // Sticky underrun flag: granted FIFO ran dry before the burst finished.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
        end else if (w_starved) begin
            r_underrun <= 1'b1;
        end
    end

    // Saturating per-channel idle timers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!reset_n) begin
                r_idle_tmr[i] <= 16'd0;
            end else if (w_tmr_hold[i]) begin
                r_idle_tmr[i] <= 16'd0;
            end else if (r_idle_tmr[i] != 16'hFFFF) begin
                r_idle_tmr[i] <= r_idle_tmr[i] + 16'd1;
            end
        end
    end

    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign out_first    = r_out_first;
    assign out_last     = r_out_last;
    assign out_ch       = r_grant;
    assign busy         = r_busy;
    assign underrun_err = r_underrun;

endmodule

// File: tb/tb_tds_channel_readout_arbiter.sv
// Bench for tds_channel_readout_arbiter: FIFO model per channel, a
// round-robin burst predictor built from queues/arrays, and a scoreboard
// checking every accepted word.
module tb_tds_channel_readout_arbiter;

    localparam int NUM_CH    = 8;
    localparam int DATA_W    = 120;
    localparam int CNT_W     = 10;
    localparam int BURST_MAX = 64;
    localparam int DEPTH     = 512;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     enable;
    logic [CNT_W-1:0]         counter_th;
    logic [15:0]              idle_th;
    logic [NUM_CH-1:0]        channel_linked;
    logic [NUM_CH-1:0]        ch_empty;
    logic [NUM_CH*CNT_W-1:0]  ch_count;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_read;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_first;
    logic                     out_last;
    logic [2:0]               out_ch;
    logic                     busy;
    logic                     underrun_err;

    tds_channel_readout_arbiter #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .counter_th(counter_th),
        .idle_th(idle_th), .channel_linked(channel_linked), .ch_empty(ch_empty),
        .ch_count(ch_count), .ch_data(ch_data), .ch_read(ch_read),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last), .out_ch(out_ch),
        .busy(busy), .underrun_err(underrun_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]        ch;
        logic [DATA_W-1:0] d;
        logic              f;
        logic              l;
    } exp_t;

    exp_t              expq[$];
    logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
    int                rd [NUM_CH];
    int                wr [NUM_CH];
    int                pops [NUM_CH];
    logic [NUM_CH-1:0] force_empty;
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                acc_cnt = 0;
    int                first_acc_cyc = 0;
    int                last_acc_cyc = 0;
    int                pred_ptr = 0;
    int                load_cyc = 0;
    bit                rand_ready = 1'b0;
    bit                toggle_ready = 1'b0;
    logic [NUM_CH-1:0] s_pop;
    logic              s_valid;
    logic              s_busy;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    task automatic load(input int ch, input int n);
        for (int j = 0; j < n; j++) begin
            mem[ch][wr[ch]] = rnd_word();
            wr[ch]++;
        end
    endtask

    task automatic drive_fifo();
        int occ;
        for (int i = 0; i < NUM_CH; i++) begin
            occ = wr[i] - rd[i];
            ch_empty[i] = (occ == 0) || force_empty[i];
            ch_count[i*CNT_W +: CNT_W] = CNT_W'((occ > 1023) ? 1023 : occ);
            ch_data[i*DATA_W +: DATA_W] = (occ > 0) ? mem[i][rd[i]] : '0;
        end
    endtask

    // Expected word stream: repeatedly grant the first eligible channel at or
    // after the pointer, burst min(fill, BURST_MAX) words, move past it.
    task automatic predict(input int max_bursts);
        int rem [NUM_CH];
        int pos [NUM_CH];
        int nb, found, c, cnt, n;
        exp_t e;
        for (int i = 0; i < NUM_CH; i++) begin
            rem[i] = wr[i] - rd[i];
            pos[i] = rd[i];
        end
        nb = 0;
        while (max_bursts == 0 || nb < max_bursts) begin
            found = -1;
            for (int k = 0; k < NUM_CH; k++) begin
                c   = (pred_ptr + k) % NUM_CH;
                cnt = (rem[c] > 1023) ? 1023 : rem[c];
                if (found < 0 && channel_linked[c] && rem[c] > 0 && cnt >= int'(counter_th))
                    found = c;
            end
            if (found < 0) break;
            cnt = (rem[found] > 1023) ? 1023 : rem[found];
            n   = (cnt > BURST_MAX) ? BURST_MAX : cnt;
            for (int j = 0; j < n; j++) begin
                e.ch = 3'(found);
                e.d  = mem[found][pos[found]];
                e.f  = (j == 0);
                e.l  = (j == n - 1);
                expq.push_back(e);
                pos[found]++;
            end
            rem[found] -= n;
            pred_ptr = (found + 1) % NUM_CH;
            nb++;
        end
    endtask

    // One clock: sample mid-cycle, then update FIFO model after the edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        s_pop   = ch_read;
        s_valid = out_valid;
        s_busy  = busy;
        if (reset_n) begin
            chk("rd_onehot", $countones(ch_read) <= 1, 1'b1);
            if (out_valid && !out_ready) chk("rd_backpressure", ch_read, '0);
            for (int i = 0; i < NUM_CH; i++)
                if (s_pop[i]) chk("pop_nonempty", (wr[i] - rd[i] > 0) && !force_empty[i], 1'b1);
            if (out_valid && out_ready) begin
                acc_cnt++;
                if (acc_cnt == 1) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                chk("sb_avail", expq.size() > 0, 1'b1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("sb_ch", out_ch, e.ch);
                    chk("sb_data", out_data, e.d);
                    chk("sb_first", out_first, e.f);
                    chk("sb_last", out_last, e.l);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++)
            if (s_pop[i]) begin
                rd[i]++;
                pops[i]++;
            end
        if (rand_ready) out_ready = ($urandom_range(0, 99) < 70);
        if (toggle_ready) out_ready = !out_ready;
        drive_fifo();
        cyc++;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((expq.size() != 0 || busy) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", expq.size(), 0);
        chk("idle_after", busy, 1'b0);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n = 0;
        while (acc_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        chk("acc_reached", acc_cnt >= target, 1'b1);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        enable       = 1'b1;
        rand_ready   = 1'b0;
        toggle_ready = 1'b0;
        out_ready    = 1'b1;
        force_empty  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd[i] = 0; wr[i] = 0; pops[i] = 0;
        end
        drive_fifo();
        cycle();
        cycle();
        reset_n  = 1'b1;
        expq.delete();
        pred_ptr = 0;
        acc_cnt  = 0;
    endtask

    task automatic chk_outputs_zero();
        chk("z_ch_read", ch_read, '0);
        chk("z_out_valid", out_valid, 1'b0);
        chk("z_out_first", out_first, 1'b0);
        chk("z_out_last", out_last, 1'b0);
        chk("z_out_data", out_data, '0);
        chk("z_out_ch", out_ch, 3'd0);
        chk("z_busy", busy, 1'b0);
        chk("z_underrun", underrun_err, 1'b0);
    endtask

    initial begin
        exp_t e;
        int   cntb;
        reset_n = 1'b0; enable = 1'b0; counter_th = '0; idle_th = 16'd0;
        channel_linked = '0; out_ready = 1'b1; force_empty = '0;
        ch_empty = '1; ch_count = '0; ch_data = '0;

        // Reset state
        do_reset();
        chk_outputs_zero();

        // Single channel, 5 words, threshold 4
        channel_linked = '1; counter_th = 10'd4;
        load(2, 5); drive_fifo(); predict(0);
        load_cyc = cyc;
        cycle();
        chk("s_busy_k0", s_busy, 1'b0);
        cycle();
        chk("s_busy_k1", s_busy, 1'b1);
        chk("s_read_k1", s_pop, 8'h04);
        chk("s_valid_k1", s_valid, 1'b0);
        cycle();
        chk("s_valid_k2", s_valid, 1'b1);
        wait_done(100);
        chk("s_words", acc_cnt, 5);
        chk("s_latency", first_acc_cyc - load_cyc, 2);
        chk("s_back2back", last_acc_cyc - first_acc_cyc, 4);
        chk("s_pops", pops[2], 5);

        // Round robin over ch0/ch3/ch5 with burst cap
        do_reset();
        channel_linked = 8'b0010_1001; counter_th = 10'd1;
        load(0, 150); load(3, 150); load(5, 150); drive_fifo(); predict(0);
        wait_done(2000);
        chk("rr_pops0", pops[0], 150);
        chk("rr_pops3", pops[3], 150);
        chk("rr_pops5", pops[5], 150);

        // Burst cap with toggling ready, enable dropped mid-burst
        do_reset();
        channel_linked = '1; counter_th = 10'd1;
        load(1, 200); drive_fifo(); predict(1);
        toggle_ready = 1'b1;
        wait_acc(3, 200);
        enable = 1'b0;
        wait_done(500);
        cntb = 0;
        repeat (30) begin
            cycle();
            if (s_busy) cntb++;
        end
        chk("en_no_regrant", cntb, 0);
        chk("bp_pops", pops[1], 64);
        chk("bp_words", acc_cnt, 64);

        // Underrun: FIFO forced empty mid-burst
        do_reset();
        channel_linked = '1; counter_th = 10'd1;
        load(6, 10); drive_fifo(); predict(0);
        wait_acc(3, 100);
        chk("ur_pre", underrun_err, 1'b0);
        force_empty[6] = 1'b1; drive_fifo();
        cntb = 0;
        repeat (5) begin
            cycle();
            if (s_pop != '0) cntb++;
        end
        chk("ur_stall", cntb, 0);
        chk("ur_flag", underrun_err, 1'b1);
        force_empty = '0; drive_fifo();
        wait_done(200);
        chk("ur_sticky", underrun_err, 1'b1);
        chk("ur_pops", pops[6], 10);

        // Reset mid-burst, next grant from ch0
        do_reset();
        channel_linked = '1; counter_th = 10'd1;
        load(3, 20); drive_fifo(); predict(0);
        wait_acc(5, 100);
        reset_n = 1'b0;
        cycle();
        chk("rst_no_pop", s_pop, '0);
        reset_n = 1'b1;
        chk_outputs_zero();
        expq.delete(); pred_ptr = 0; acc_cnt = 0;
        load(0, 3); drive_fifo(); predict(0);
        wait_done(300);
        chk("rst_pops0", pops[0], 3);
        chk("rst_pops3", pops[3], 20);

        // Idle timeout grants a below-threshold channel after 100 cycles
        do_reset();
        channel_linked = '1; counter_th = 10'd10; idle_th = 16'd100;
        load(4, 1); drive_fifo();
        e.ch = 3'd4; e.d = mem[4][0]; e.f = 1'b1; e.l = 1'b1;
        expq.push_back(e);
        cntb = 0;
        repeat (101) begin
            cycle();
            if (s_busy) cntb++;
        end
        chk("to_early", cntb, 0);
        cycle();
        chk("to_grant", s_busy, 1'b1);
        wait_done(50);
        chk("to_pops", pops[4], 1);

        // Timeout path disabled
        do_reset();
        channel_linked = '1; counter_th = 10'd10; idle_th = 16'd0;
        load(4, 1); drive_fifo();
        cntb = 0;
        repeat (300) begin
            cycle();
            if (s_busy) cntb++;
        end
        chk("to_off_busy", cntb, 0);
        chk("to_off_pops", pops[4], 0);

        // Randomized fills, links, thresholds and ready
        for (int it = 0; it < 3; it++) begin
            do_reset();
            channel_linked = NUM_CH'($urandom());
            counter_th     = CNT_W'($urandom_range(0, 40));
            idle_th        = 16'd0;
            for (int i = 0; i < NUM_CH; i++) load(i, $urandom_range(0, 150));
            drive_fifo();
            predict(0);
            rand_ready = 1'b1;
            wait_done(6000);
            rand_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tds_channel_readout_arbiter.md
# tds_channel_readout_arbiter

Round-robin scheduler that shares the single readout packer/Ethernet TX path among up to NUM_CH TDS channel FIFOs. Each channel is judged eligible by its FIFO fill level against a threshold, or by an idle timeout. One channel at a time is granted a bounded burst: the arbiter pops its FIFO and forwards 120-bit words over a valid/ready stream with first/last framing and a channel tag. Sits between the per-channel decoder FIFOs and the frame builder, in the 160 MHz domain.

## Interface
- NUM_CH, 8: number of channel FIFOs (2..8)
- DATA_W, 120: channel word width
- CNT_W, 10: FIFO data-count width
- BURST_MAX, 64: maximum words per grant (1..2^CNT_W-1)
- clk  in  1  160 MHz clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  permits new grants; ignored for a burst in progress
- counter_th  in  CNT_W  fill threshold; 0 = any non-empty channel qualifies on fill
- idle_th  in  16  idle-timeout threshold in cycles; 0 = timeout path disabled
- channel_linked  in  NUM_CH  per-channel link-up; unlinked channels never granted
- ch_empty  in  NUM_CH  FWFT FIFO empty flags
- ch_count  in  NUM_CH*CNT_W  FIFO read data counts, channel i at [i*CNT_W +: CNT_W]; guaranteed ≤ true occupancy
- ch_data  in  NUM_CH*DATA_W  FWFT head words, channel i at [i*DATA_W +: DATA_W]
- ch_read  out  NUM_CH  one-hot pop strobe
- out_data  out  DATA_W  forwarded word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept
- out_first  out  1  first word of burst
- out_last  out  1  last word of burst
- out_ch  out  3  granted channel index
- busy  out  1  high in BURST or DRAIN
- underrun_err  out  1  sticky: granted FIFO went empty mid-burst; cleared only by reset

## Operation
- States: IDLE, BURST, DRAIN.
- Eligibility of channel i (combinational): channel_linked[i] & !ch_empty[i] & ((ch_count_i ≥ counter_th) | (idle_th≠0 & idle_tmr[i] ≥ idle_th)).
- idle_tmr[i], 16 bit: cleared when ch_empty[i] or when i is granted; otherwise +1 per cycle, saturating at 0xFFFF.
- IDLE: if enable and any channel is eligible, pick the first eligible index at or above rr_ptr, modulo NUM_CH. Register grant ← index, words_left ← min(ch_count_grant, BURST_MAX), first_pend ← 1, state ← BURST.
- BURST: ch_read[grant] = (!out_valid | out_ready) & !ch_empty[grant] & words_left≠0. On each pop:
  - out_data ← ch_data[grant], out_valid ← 1, out_first ← first_pend, out_last ← (words_left==1).
  - words_left −1; first_pend ← 0.
  - On the pop with words_left==1, state ← DRAIN.
- BURST with ch_empty[grant] while words_left≠0: stall (no pop) and set underrun_err.
- Output register: if out_valid & out_ready with no pop that cycle, then out_valid ← 0. out_first and out_last qualify only when out_valid.
- DRAIN: when out_valid & out_ready, rr_ptr ← (grant+1) mod NUM_CH, state ← IDLE.
- out_ch is held at grant from the grant cycle until IDLE is re-entered.
- Deasserting enable during BURST or DRAIN does not abort; the burst completes.
- Reset (any state, mid-burst included): state IDLE, rr_ptr 0, all idle_tmr 0. Outputs reset to: ch_read 0, out_valid 0, out_first 0, out_last 0, out_data 0, out_ch 0, busy 0, underrun_err 0. No FIFO pop on the reset cycle.

## Timing
- Eligibility in IDLE at cycle n → BURST at n+1, first ch_read at n+1 → out_valid at n+2.
- Sustained throughput 1 word/cycle while out_ready=1. No bubbles inside a burst.
- The last word accepted at cycle m → IDLE at m+1 → next grant evaluation at m+1 → next out_valid at m+3 at the earliest.
- ch_read is combinational from registered state, out_valid, out_ready, and ch_empty. It is never asserted outside BURST and never for more than one channel.
- ch_count is sampled only at the grant cycle. Later changes do not alter the burst length.

## Test plan
- Single channel: ch2 linked with count 5, counter_th=4, out_ready=1 → 5 words tagged out_ch=2 on consecutive cycles; out_first on word 1, out_last on word 5; exactly 5 ch_read[2] pulses; first out_valid 2 cycles after eligibility.
- Round robin: ch0, ch3, ch5 all eligible and continuously refilled → grant order 0,3,5,0,…; rr_ptr advances after each DRAIN.
- Burst cap and backpressure: ch1 count=200, BURST_MAX=64, out_ready toggling 1/0 → exactly 64 words, none dropped or duplicated, out_last on word 64; ch_read is low whenever out_valid & !out_ready.
- Idle timeout: ch4 holds 1 word, counter_th=10, idle_th=100 → no grant before 100 non-empty cycles, grant once idle_tmr reaches 100, 1-word burst with out_first=out_last=1. With idle_th=0 → never granted.
- Edge conditions: enable dropped mid-burst → burst completes, then no new grant. ch_empty forced high mid-burst → stall and underrun_err=1. reset_n low mid-burst → all outputs 0 next cycle, and the next grant starts from ch0.
